// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory read-modify-write controller:
// access-type codes, FSM state encoding and small decode helpers.
package dm_pkg;

  // Access type codes carried on req_dmtype.
  localparam logic [2:0] DM_WORD   = 3'b000;
  localparam logic [2:0] DM_HALF   = 3'b001;
  localparam logic [2:0] DM_HALF_U = 3'b010;
  localparam logic [2:0] DM_BYTE   = 3'b011;
  localparam logic [2:0] DM_BYTE_U = 3'b100;

  // Controller states.
  typedef enum logic [2:0] {
    IDLE,
    RD,
    RDW,
    WR,
    DONE
  } dm_state_t;

  // Access width after decoding the type code.
  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } dm_size_t;

  // Unknown codes fall back to a full-word access.
  function automatic dm_size_t dm_size(input logic [2:0] dmtype);
    dm_size_t size;
    case (dmtype)
      DM_HALF, DM_HALF_U: size = SZ_HALF;
      DM_BYTE, DM_BYTE_U: size = SZ_BYTE;
      default:            size = SZ_WORD;
    endcase
    return size;
  endfunction

  // Only the two signed sub-word codes sign-extend; words need no extension.
  function automatic logic dm_is_signed(input logic [2:0] dmtype);
    return (dmtype == DM_HALF) || (dmtype == DM_BYTE);
  endfunction

  // Halves must sit on an even byte, words on a multiple of four.
  function automatic logic dm_misaligned(input logic [2:0] dmtype,
                                         input logic [1:0] lane);
    logic mis;
    case (dm_size(dmtype))
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = lane[0];
      default: mis = |lane;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dm_lane_unit.sv
// Combinational lane logic: extracts and extends a loaded byte/half/word
// from a RAM word, and merges right-aligned store data into an old word.
module dm_lane_unit
  import dm_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  lane,
  input  logic [2:0]  dmtype,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  dm_size_t    size;
  logic        sign_ext;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign size     = dm_size(dmtype);
  assign sign_ext = dm_is_signed(dmtype);

  // The selected byte lane, and the half at lanes {addr[1],0}/{addr[1],1}.
  assign byte_sel = word[{lane, 3'b000} +: 8];
  assign half_sel = word[{lane[1], 4'b0000} +: 16];

  // Load path: pick the lane and replicate its top bit or zero-fill.
  always_comb begin
    load_data = word;
    case (size)
      SZ_BYTE: load_data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_data = {{16{sign_ext & half_sel[15]}}, half_sel};
      default: load_data = word;
    endcase
  end

  // Store path: each byte lane decides independently whether it takes new
  // data and which byte of the right-aligned store data feeds it.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE_IDX = 2'(gi);
      localparam logic       LANE_HI  = (gi >= 2);
      localparam logic       LANE_ODD = (gi % 2 == 1);

      logic       lane_en;
      logic [7:0] lane_src;

      // Byte enable and source byte for this lane.
      always_comb begin
        lane_en  = 1'b0;
        lane_src = wdata[8*gi +: 8];
        case (size)
          SZ_BYTE: begin
            lane_en  = (lane == LANE_IDX);
            lane_src = wdata[7:0];
          end
          SZ_HALF: begin
            lane_en  = (lane[1] == LANE_HI);
            lane_src = LANE_ODD ? wdata[15:8] : wdata[7:0];
          end
          default: begin
            lane_en  = 1'b1;
            lane_src = wdata[8*gi +: 8];
          end
        endcase
      end

      assign merged[8*gi +: 8] = lane_en ? lane_src : word[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/dm_rmw_ctrl.sv
// Data-memory access controller: one load/store at a time between the CPU
// memory stage and a word-only synchronous RAM. Sub-word stores become
// read-modify-write sequences; loads are lane-extracted and extended.
module dm_rmw_ctrl
  import dm_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [2:0]        req_dmtype,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  dm_state_t state_reg;
  dm_state_t state_next;

  // Latched request.
  logic [ADDR_W-1:0] addr_reg;
  logic [1:0]        lane_reg;
  logic [2:0]        dmtype_reg;
  logic              we_reg;
  logic [31:0]       wdata_reg;

  // Word to be written in WR, extended load result, error flag.
  logic [31:0]       wr_word_reg;
  logic [31:0]       rdata_reg;
  logic              err_reg;

  logic              accept;
  logic              req_misaligned;
  logic              req_is_word;
  logic [31:0]       lane_load;
  logic [31:0]       lane_merged;
  logic              unused_addr_hi;

  // Byte-address bits above the RAM window are don't-care.
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  assign req_misaligned = dm_misaligned(req_dmtype, req_addr[1:0]);
  assign req_is_word    = (dm_size(req_dmtype) == SZ_WORD);
  assign accept         = req_valid && (state_reg == IDLE);

  dm_lane_unit u_lane (
    .word      (ram_rdata),
    .wdata     (wdata_reg),
    .lane      (lane_reg),
    .dmtype    (dmtype_reg),
    .load_data (lane_load),
    .merged    (lane_merged)
  );

  // State register; reset aborts any in-flight access immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decode and per-state strobes. ram_we is purely a function of
  // the state so an asynchronous reset drops it without waiting for a clock.
  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    ram_we     = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_misaligned) begin
            state_next = DONE;
          end else if (req_we && req_is_word) begin
            state_next = WR;
          end else begin
            state_next = RD;
          end
        end
      end
      RD: begin
        state_next = RDW;
      end
      RDW: begin
        state_next = we_reg ? WR : DONE;
      end
      WR: begin
        ram_we     = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        resp_valid = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request latch on accept, then capture of RAM data in RDW: loads keep the
  // extended lane, sub-word stores keep the merged word for the WR cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_reg    <= '0;
      lane_reg    <= '0;
      dmtype_reg  <= DM_WORD;
      we_reg      <= 1'b0;
      wdata_reg   <= '0;
      wr_word_reg <= '0;
      rdata_reg   <= '0;
      err_reg     <= 1'b0;
    end else begin
      if (accept) begin
        addr_reg    <= req_addr[ADDR_W+1:2];
        lane_reg    <= req_addr[1:0];
        dmtype_reg  <= req_dmtype;
        we_reg      <= req_we;
        wdata_reg   <= req_wdata;
        wr_word_reg <= req_wdata;
        rdata_reg   <= '0;
        err_reg     <= req_misaligned;
      end else if (state_reg == RDW) begin
        if (we_reg) begin
          wr_word_reg <= lane_merged;
        end else begin
          rdata_reg <= lane_load;
        end
      end
    end
  end

  assign ram_addr   = addr_reg;
  assign ram_wdata  = (state_reg == WR) ? wr_word_reg : '0;
  assign resp_rdata = rdata_reg;
  assign resp_err   = err_reg & resp_valid;

endmodule

// File: tb/tb_dm_rmw_ctrl.sv
// Self-checking bench for dm_rmw_ctrl: directed steps from the test plan
// followed by random accesses, all compared against a byte-level model.
module tb_dm_rmw_ctrl;
  import dm_pkg::*;

  localparam int ADDR_W = 10;

  logic              clk        = 1'b0;
  logic              reset      = 1'b1;
  logic              req_valid  = 1'b0;
  logic              req_we     = 1'b0;
  logic [31:0]       req_addr   = '0;
  logic [31:0]       req_wdata  = '0;
  logic [2:0]        req_dmtype = '0;
  logic              req_ready;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata  = '0;

  always #5 clk = ~clk;

  dm_rmw_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_dmtype (req_dmtype),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  // Synchronous word RAM with a side port for preloading.
  logic [31:0] tb_ram [0:1023];
  logic        tb_wr_en   = 1'b0;
  logic [9:0]  tb_wr_idx  = '0;
  logic [31:0] tb_wr_data = '0;

  always @(posedge clk) begin
    if (tb_wr_en) tb_ram[tb_wr_idx] <= tb_wr_data;
    else if (ram_we) tb_ram[ram_addr] <= ram_wdata;
    ram_rdata <= tb_ram[ram_addr];
  end

  // Activity monitors.
  int         we_count     = 0;
  int         resp_count   = 0;
  logic [9:0] last_we_addr = '0;

  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      we_count     <= we_count + 1;
      last_we_addr <= ram_addr;
    end
    if (resp_valid === 1'b1) resp_count <= resp_count + 1;
  end

  // Reference model state and expectations for the current request.
  logic [31:0] ref_mem [0:1023];
  logic [31:0] exp_rdata;
  logic        exp_err;
  int          exp_lat;
  int          exp_we;
  int          exp_idx;
  int          we_base;
  logic [31:0] last_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] val);
    tb_wr_en   = 1'b1;
    tb_wr_idx  = idx[9:0];
    tb_wr_data = val;
    ref_mem[idx] = val;
    @(posedge clk);
    #1 tb_wr_en = 1'b0;
    @(negedge clk);
  endtask

  // Byte-level behavioural model of one access.
  task automatic prep(input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [2:0] dt);
    int size;
    int off;
    logic sgn;
    logic [31:0] v;
    logic [31:0] mask;
    case (dt)
      3'd1, 3'd2: size = 2;
      3'd3, 3'd4: size = 1;
      default:    size = 4;
    endcase
    sgn       = (dt == 3'd1) || (dt == 3'd3);
    exp_idx   = int'((addr >> 2) % 1024);
    off       = int'(addr % 4);
    exp_rdata = '0;
    exp_we    = 0;
    exp_err   = 1'b0;
    if ((off % size) != 0) begin
      exp_err = 1'b1;
      exp_lat = 1;
    end else if (we) begin
      exp_we = 1;
      exp_lat = (size == 4) ? 2 : 4;
      v = ref_mem[exp_idx];
      for (int i = 0; i < size; i++) v[8*(off+i) +: 8] = wdata[8*i +: 8];
      ref_mem[exp_idx] = v;
    end else begin
      exp_lat = 3;
      v = ref_mem[exp_idx] >> (8*off);
      if (size < 4) begin
        mask = (32'd1 << (8*size)) - 32'd1;
        v = v & mask;
        if (sgn && v[8*size-1]) v = v | ~mask;
      end
      exp_rdata = v;
    end
    we_base = we_count;
  endtask

  task automatic issue(input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] dt);
    prep(we, addr, wdata, dt);
    req_we     = we;
    req_addr   = addr;
    req_wdata  = wdata;
    req_dmtype = dt;
    req_valid  = 1'b1;
  endtask

  // Waits for the response; returns at the negedge where resp_valid is high.
  task automatic wait_resp(input string tag);
    int lat = 0;
    bit early = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        lat = c;
        break;
      end
      if (req_ready !== 1'b0) early = 1'b1;
    end
    last_rdata = resp_rdata;
    chk({tag, "_lat"},   32'(lat), 32'(exp_lat));
    chk({tag, "_rdata"}, resp_rdata, exp_rdata);
    chk({tag, "_err"},   32'(resp_err), 32'(exp_err));
    chk({tag, "_wecnt"}, 32'(we_count - we_base), 32'(exp_we));
    if (exp_we == 1) chk({tag, "_weaddr"}, 32'(last_we_addr), 32'(exp_idx));
    chk({tag, "_ram"},   tb_ram[exp_idx], ref_mem[exp_idx]);
    chk({tag, "_busy"},  32'(early), 0);
  endtask

  // One complete access; junk is driven on req_* while the controller is busy.
  task automatic run_op(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] dt);
    issue(we, addr, wdata, dt);
    chk({tag, "_ready"}, 32'(req_ready), 1);
    @(posedge clk);
    #1;
    req_we     = 1'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    req_dmtype = 3'($urandom);
    wait_resp(tag);
    req_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(resp_valid), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_we;
    int base_resp;

    // Reset values.
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready",  32'(req_ready),  1);
    chk("rst_rvalid", 32'(resp_valid), 0);
    chk("rst_err",    32'(resp_err),   0);
    chk("rst_rdata",  resp_rdata,      0);
    chk("rst_we",     32'(ram_we),     0);
    chk("rst_addr",   32'(ram_addr),   0);
    chk("rst_wdata",  ram_wdata,       0);

    for (int i = 0; i < 32; i++) poke(i, $urandom);
    reset = 1'b0;
    @(negedge clk);

    // Word store then load at 0x10.
    run_op("st_word", 1'b1, 32'h10, 32'hDEADBEEF, DM_WORD);
    chk("st_word_lit", tb_ram[4], 32'hDEADBEEF);
    run_op("ld_word", 1'b0, 32'h10, 32'h0, DM_WORD);
    chk("ld_word_lit", last_rdata, 32'hDEADBEEF);

    // Byte store RMW and signed/unsigned byte loads.
    poke(4, 32'h11223344);
    run_op("st_byte", 1'b1, 32'h13, 32'h000000AA, DM_BYTE);
    chk("st_byte_lit", tb_ram[4], 32'hAA223344);
    run_op("ld_byte", 1'b0, 32'h13, 32'h0, DM_BYTE);
    chk("ld_byte_lit", last_rdata, 32'hFFFFFFAA);
    run_op("ld_byteu", 1'b0, 32'h13, 32'h0, DM_BYTE_U);
    chk("ld_byteu_lit", last_rdata, 32'h000000AA);

    // Half store RMW and signed/unsigned half loads.
    poke(8, 32'h00000000);
    run_op("st_half", 1'b1, 32'h22, 32'h00008001, DM_HALF);
    chk("st_half_lit", tb_ram[8], 32'h80010000);
    run_op("ld_half", 1'b0, 32'h22, 32'h0, DM_HALF);
    chk("ld_half_lit", last_rdata, 32'hFFFF8001);
    run_op("ld_halfu", 1'b0, 32'h22, 32'h0, DM_HALF_U);
    chk("ld_halfu_lit", last_rdata, 32'h00008001);

    // Misaligned accesses.
    run_op("mis_ld", 1'b0, 32'h21, 32'h0, DM_HALF);
    run_op("mis_st", 1'b1, 32'h02, 32'h12345678, DM_WORD);

    // Back-to-back: byte store then word load of the same word, valid held.
    issue(1'b1, 32'h15, 32'h0000005A, DM_BYTE);
    chk("b2b1_ready", 32'(req_ready), 1);
    @(posedge clk);
    #1;
    req_we     = 1'b0;
    req_addr   = 32'h14;
    req_wdata  = $urandom;
    req_dmtype = DM_WORD;
    wait_resp("b2b1");
    chk("b2b_ready_done", 32'(req_ready), 0);
    prep(1'b0, 32'h14, req_wdata, DM_WORD);
    @(negedge clk);
    chk("b2b_ready_idle", 32'(req_ready), 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_resp("b2b2");
    @(negedge clk);

    // Reset during RDW of a byte store.
    poke(12, 32'h55555555);
    req_we     = 1'b1;
    req_addr   = 32'h30;
    req_wdata  = 32'h00000077;
    req_dmtype = DM_BYTE;
    req_valid  = 1'b1;
    chk("abort_ready", 32'(req_ready), 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    base_we   = we_count;
    base_resp = resp_count;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_we_rst",    32'(ram_we),    0);
    chk("abort_ready_rst", 32'(req_ready), 1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_ready_rel", 32'(req_ready), 1);
    repeat (4) @(negedge clk);
    chk("abort_wecnt", 32'(we_count - base_we), 0);
    chk("abort_resp",  32'(resp_count - base_resp), 0);
    chk("abort_ram",   tb_ram[12], 32'h55555555);

    // Random accesses over the first 32 words, with random upper address bits.
    for (int i = 0; i < 60; i++) begin
      logic        r_we;
      logic [31:0] r_addr;
      logic [31:0] r_wdata;
      logic [2:0]  r_dt;
      r_we    = 1'($urandom_range(0, 1));
      r_addr  = ($urandom & 32'hFFFFF000) | $urandom_range(0, 127);
      r_wdata = $urandom;
      r_dt    = 3'($urandom_range(0, 7));
      run_op($sformatf("rnd%0d", i), r_we, r_addr, r_wdata, r_dt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
